mips_mem_arbiter: RTL

- Shares the single Avalon-MM master port between three requesters: the instruction-cache read port, the data-cache read port and the write-buffer drain port.
- The write-buffer port connects directly to the write buffer's write_addr/write_data/write_byteenable/write_writeenable outputs and full/empty flags.
- Grants one non-pipelined transaction at a time.
- Drains pending writes ahead of data reads to keep read-after-write order.
- Bounds instruction-fetch starvation with a counter.

---
 rtl/mips_bus_pkg.sv | 19 +
 rtl/mips_mem_arbiter_if.sv | 55 +++++
 rtl/mips_arb_starve_counter.sv | 40 ++++
 rtl/mips_mem_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the MIPS memory arbiter.
// Revision 1.0
`default_nettype none

package mips_bus_pkg;

  localparam int         AVM_ADDR_W = 32;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_READ_I = 2'd1,
    ARB_READ_D = 2'd2,
    ARB_WRITE  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: requester ports (I-cache, D-cache, write buffer) and Avalon-MM master.
// Revision 1.0
`default_nettype none

interface mips_mem_arbiter_if
  import mips_bus_pkg::*;
();

  logic                  i_read;
  logic [AVM_ADDR_W-1:0] i_addr;
  logic [31:0]           i_readdata;
  logic                  i_waitrequest;

  logic                  d_read;
  logic [AVM_ADDR_W-1:0] d_addr;
  logic [31:0]           d_readdata;
  logic                  d_waitrequest;

  logic                  wb_write;
  logic [AVM_ADDR_W-1:0] wb_addr;
  logic [31:0]           wb_writedata;
  logic [3:0]            wb_byteenable;
  logic                  wb_full;
  logic                  wb_empty;
  logic                  wb_waitrequest;

  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic [3:0]            avm_byteenable;
  logic [31:0]           avm_readdata;
  logic                  avm_waitrequest;

  // Arbiter side: serves the requesters, masters the Avalon bus.
  modport master (
    input  i_read, i_addr, d_read, d_addr,
    input  wb_write, wb_addr, wb_writedata, wb_byteenable, wb_full, wb_empty,
    input  avm_readdata, avm_waitrequest,
    output i_readdata, i_waitrequest, d_readdata, d_waitrequest, wb_waitrequest,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  // Environment side: requesters plus the Avalon slave.
  modport slave (
    output i_read, i_addr, d_read, d_addr,
    output wb_write, wb_addr, wb_writedata, wb_byteenable, wb_full, wb_empty,
    output avm_readdata, avm_waitrequest,
    input  i_readdata, i_waitrequest, d_readdata, d_waitrequest, wb_waitrequest,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

endinterface

`default_nettype wire

// File: rtl/mips_arb_starve_counter.sv
// mips_arb_starve_counter: saturating count of write grants taken while an instruction fetch waits.
// Revision 1.0
`default_nettype none

module mips_arb_starve_counter #(
  parameter int LIMIT    = 4,
  parameter int CNT_BITS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  assign at_limit_o = (cnt_q == CNT_BITS'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: one-at-a-time Avalon-MM arbiter for I-fetch, D-read and write-buffer drain.
// Revision 1.0
`default_nettype none

module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic                clk,
  input  logic                rst,
  mips_mem_arbiter_if.master  bus,
  output logic [1:0]          state_out
);

  localparam logic [1:0] S_IDLE   = 2'(ARB_IDLE);
  localparam logic [1:0] S_READ_I = 2'(ARB_READ_I);
  localparam logic [1:0] S_READ_D = 2'(ARB_READ_D);
  localparam logic [1:0] S_WRITE  = 2'(ARB_WRITE);

  if ((1 << CNT_BITS) <= STARVE_LIMIT) begin : g_cnt_bits_check
    $error("CNT_BITS too narrow to hold STARVE_LIMIT");
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       w_done;
  logic       w_at_limit;
  logic       w_starve_inc;
  logic       w_starve_clr;
  logic       w_done_i;
  logic       w_done_d;
  logic       w_done_wb;

  assign w_done    = (state_q != S_IDLE) && !bus.avm_waitrequest;
  assign w_done_i  = w_done && (state_q == S_READ_I);
  assign w_done_d  = w_done && (state_q == S_READ_D);
  assign w_done_wb = w_done && (state_q == S_WRITE);

  // Pending writes win over data reads so a read never overtakes a buffered store.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_read && w_at_limit) begin
          state_d = S_READ_I;
        end else if (bus.wb_write && (bus.wb_full || bus.d_read)) begin
          state_d = S_WRITE;
        end else if (bus.d_read && bus.wb_empty) begin
          state_d = S_READ_D;
        end else if (bus.i_read) begin
          state_d = S_READ_I;
        end else if (bus.wb_write) begin
          state_d = S_WRITE;
        end
      end
      default: begin
        if (w_done) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_starve_inc = w_done_wb && bus.i_read;
  assign w_starve_clr = w_done_i || ((state_q == S_IDLE) && !bus.i_read);

  mips_arb_starve_counter #(
    .LIMIT    (STARVE_LIMIT),
    .CNT_BITS (CNT_BITS)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (w_starve_inc),
    .clr_i      (w_starve_clr),
    .at_limit_o (w_at_limit)
  );

  always_comb begin
    bus.avm_address    = '0;
    bus.avm_read       = 1'b0;
    bus.avm_write      = 1'b0;
    bus.avm_writedata  = '0;
    bus.avm_byteenable = '0;
    case (state_q)
      S_READ_I: begin
        bus.avm_address    = bus.i_addr;
        bus.avm_read       = 1'b1;
        bus.avm_byteenable = BYTEEN_ALL;
      end
      S_READ_D: begin
        bus.avm_address    = bus.d_addr;
        bus.avm_read       = 1'b1;
        bus.avm_byteenable = BYTEEN_ALL;
      end
      S_WRITE: begin
        bus.avm_address    = bus.wb_addr;
        bus.avm_write      = 1'b1;
        bus.avm_writedata  = bus.wb_writedata;
        bus.avm_byteenable = bus.wb_byteenable;
      end
      default: ;
    endcase
  end

  assign bus.i_waitrequest  = bus.i_read   && !w_done_i;
  assign bus.d_waitrequest  = bus.d_read   && !w_done_d;
  assign bus.wb_waitrequest = bus.wb_write && !w_done_wb;
  assign bus.i_readdata     = w_done_i ? bus.avm_readdata : '0;
  assign bus.d_readdata     = w_done_d ? bus.avm_readdata : '0;
  assign state_out          = state_q;

endmodule

`default_nettype wire
